// File: rtl/hex_rate_counter_pkg.sv
// Shared definitions for the hex rate counter.
// Holds the speed encodings, the divider width and the period function.
package hex_rate_counter_pkg;

  // Divider width; 4 * 50 MHz - 1 fits in 28 bits.
  localparam int unsigned DIV_W = 28;
  // Width used while computing the period, so that the multiply by 4 cannot overflow.
  localparam int unsigned PW    = DIV_W + 2;

  localparam logic [1:0] SPD_FULL = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_2S   = 2'b10;
  localparam logic [1:0] SPD_4S   = 2'b11;

  // Step period in clocks for a given speed setting.
  function automatic logic [PW-1:0] period(input logic [1:0] spd, input int unsigned clk_hz);
    logic [PW-1:0] p;
    case (spd)
      SPD_FULL: p = PW'(1);
      SPD_1HZ:  p = PW'(clk_hz);
      SPD_2S:   p = PW'(clk_hz) << 1;
      default:  p = PW'(clk_hz) << 2;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable down-counting divider that produces the step strobe.
// Ports: clock, resetn (async, active low), enable, load, speed[1:0] in;
//        tick out (combinational step strobe).
module rate_divider
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       load,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] reload;
  logic [1:0]       speed_q;
  logic             cnt_zero;
  logic             speed_same;

  // Reload value P(speed)-1 for the currently selected speed.
  always_comb begin
    reload = DIV_W'(period(speed, CLK_HZ) - PW'(1));
  end

  assign cnt_zero   = (div_cnt_q == '0);
  assign speed_same = (speed == speed_q);

  // A speed change suppresses the strobe so the new period starts cleanly.
  assign tick = enable & ~load & cnt_zero & speed_same;

  // Next divider value: load, then speed change, then enable, then hold.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (load || !speed_same) begin
      div_cnt_d = reload;
    end else if (enable) begin
      if (cnt_zero) div_cnt_d = reload;
      else          div_cnt_d = div_cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      speed_q   <= SPD_FULL;
    end else begin
      div_cnt_q <= div_cnt_d;
      speed_q   <= speed;
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Up/down hex digit counter stepping at a selectable rate.
// Ports: clock, resetn (async, active low), enable, speed[1:0], up, load,
//        load_value[3:0] in; digit[3:0] (registered), tick (combinational) out.
module hex_rate_counter
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] digit,
  output logic       tick
);

  logic [3:0] digit_q, digit_d;
  logic       step;

  rate_divider #(
    .CLK_HZ (CLK_HZ)
  ) u_rate_divider (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .load   (load),
    .speed  (speed),
    .tick   (step)
  );

  // Load wins; otherwise step by one on the strobe, wrapping modulo 16.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_value;
    end else if (step) begin
      digit_d = up ? (digit_q + 4'(1)) : (digit_q - 4'(1));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) digit_q <= 4'h0;
    else         digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign tick  = step;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Randomised and directed bench for hex_rate_counter with a scoreboard.
module tb_hex_rate_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       clock;
  logic       resetn;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] digit;
  logic       tick;

  hex_rate_counter #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .speed      (speed),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .digit      (digit),
    .tick       (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       tick;
    logic [3:0] digit;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: digit value, clocks left before the next step, last speed seen.
  int m_digit;
  int m_left;
  int m_prev;

  function automatic int clocks_per_step(input int spd);
    if (spd == 0) return 1;
    return CLK_HZ * (1 << (spd - 1));
  endfunction

  task automatic model_reset();
    m_digit = 0;
    m_left  = 0;
    m_prev  = 0;
  endtask

  // Advance the model by one edge; returns the strobe expected before that edge.
  task automatic model_edge(input int en, input int spd, input int u, input int ld,
                            input int lv, output logic exp_tick);
    exp_tick = (en != 0) && (ld == 0) && (m_left == 0) && (spd == m_prev);
    if (ld != 0) begin
      m_digit = lv;
      m_left  = clocks_per_step(spd) - 1;
    end else if (spd != m_prev) begin
      m_left  = clocks_per_step(spd) - 1;
    end else if (en != 0) begin
      if (m_left == 0) begin
        m_left  = clocks_per_step(spd) - 1;
        m_digit = (u != 0) ? (m_digit + 1) % 16 : (m_digit + 15) % 16;
      end else begin
        m_left = m_left - 1;
      end
    end
    m_prev = spd;
  endtask

  // Apply inputs for the coming edge, log the expectation, then move past that edge.
  task automatic drive(input logic en, input logic [1:0] spd, input logic u,
                       input logic ld, input logic [3:0] lv);
    exp_t e;
    logic t;
    enable     = en;
    speed      = spd;
    up         = u;
    load       = ld;
    load_value = lv;
    model_edge(int'(en), int'(spd), int'(u), int'(ld), int'(lv), t);
    e.tick  = t;
    e.digit = 4'(m_digit);
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Asynchronous reset pulse; the digit must clear without waiting for an edge.
  task automatic reset_pulse();
    resetn = 1'b0;
    #1;
    check("async_reset_digit", int'(digit), 0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    model_reset();
  endtask

  // Monitor: strobe checked mid-cycle, digit checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("tick", int'(tick), int'(e.tick));
        @(posedge clock);
        #1;
        check("digit", int'(digit), int'(e.digit));
      end
    end
  end

  initial begin
    logic [1:0] rs;
    resetn     = 1'b0;
    enable     = 1'b0;
    speed      = 2'b00;
    up         = 1'b1;
    load       = 1'b0;
    load_value = 4'h0;
    model_reset();
    #2;
    check("reset_digit", int'(digit), 0);
    check("reset_tick_dis", int'(tick), 0);
    enable = 1'b1;
    #1;
    check("reset_tick_en", int'(tick), 1);
    enable = 1'b0;
    #4;
    resetn = 1'b1;

    // Full speed counting up through the wrap.
    for (int i = 0; i < 17; i++) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0);

    // 1 Hz from reset: reload on the first edge, then a step every 4 clocks.
    reset_pulse();
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);

    // Slowest rate counting down from 0.
    drive(1'b1, 2'b11, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 34; i++) drive(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);

    // Load when the divider is due to step: load wins and the period restarts.
    for (int i = 0; i < 20 && !(m_left == 0 && m_prev == 1); i++)
      drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    check("load_at_zero_setup", m_left, 0);
    drive(1'b1, 2'b01, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 6; i++) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);

    // Speed change mid-period.
    for (int i = 0; i < 2; i++) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 12; i++) drive(1'b1, 2'b10, 1'b1, 1'b0, 4'h0);

    // Freeze mid-period then resume.
    drive(1'b1, 2'b01, 1'b1, 1'b1, 4'h3);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);

    // Reset mid-period, then full speed must step on the first enabled edge.
    drive(1'b1, 2'b01, 1'b1, 1'b1, 4'h5);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    reset_pulse();
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0);

    // Randomised traffic with mostly stable speed.
    rs = 2'b01;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) rs = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 4) != 0), rs, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end

    // Let the monitor drain; anything left over is a lost response.
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_rate_counter.md
HEX_RATE_COUNTER -- requirements
Module: hex_rate_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving the clock frequency in Hz.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: count enable; low freezes the divider and the digit.
REQ-005 The block SHALL have port speed, input, 2 bits: 00 = every clock, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz.
REQ-006 The block SHALL have port up, input, 1 bit: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port load_value, input, 4 bits: value written on load.
REQ-009 The block SHALL have port digit, output, 4 bits: current hex value, registered, fed directly to the 7-segment decoder.
REQ-010 The block SHALL have port tick, output, 1 bit: combinational; high in the cycle whose edge advances digit.

Function
REQ-011 Period P(speed) SHALL be 1, CLK_HZ, 2*CLK_HZ and 4*CLK_HZ clocks for speed 00, 01, 10 and 11.
REQ-012 The divider SHALL be a down-counter div_cnt, 28 bits wide (fits 4*50e6-1), with no truncation of P-1.
REQ-013 tick SHALL equal enable & ~load & (div_cnt==0) & (speed==speed_q), where speed_q is speed registered each clock.
REQ-014 Priority per edge SHALL be: load, then speed change, then enable, then hold.
REQ-015 On load=1, digit SHALL take load_value and div_cnt SHALL take P(speed)-1, regardless of enable.
REQ-016 On speed != speed_q (no load), div_cnt SHALL take P(speed)-1, digit SHALL hold and tick SHALL be 0.
REQ-017 On enable=1 with div_cnt==0, div_cnt SHALL take P(speed)-1 and digit SHALL step by ±1 per up.
REQ-018 On enable=1 with div_cnt!=0, div_cnt SHALL decrement by 1 and digit SHALL hold.
REQ-019 On enable=0, div_cnt and digit SHALL hold.
REQ-020 digit SHALL wrap F->0 counting up and 0->F counting down, modulo 16, with no flag.
REQ-021 At speed 00, digit SHALL step on every enabled clock, since div_cnt stays 0.
REQ-022 Toggling up SHALL take effect at the next step with no divider reload.

Reset
REQ-023 When resetn=0, the block SHALL asynchronously set digit=0, div_cnt=0 and speed_q=00; tick then reads 0 or enable per REQ-013.
REQ-024 A reset asserted mid-count SHALL abort the period; after release the first enabled edge with speed 00 SHALL step the digit.
REQ-025 A non-00 speed at reset release SHALL trigger a REQ-016 reload on the first edge.

Structure
REQ-026 A shared package SHALL hold the speed encodings SPD_FULL/SPD_1HZ/SPD_2S/SPD_4S, the divider width constant (28) and the period function P.
REQ-027 The divider (div_cnt, speed_q, tick) SHALL be one sub-module, rate_divider; the top SHALL hold the 4-bit digit register and load/step logic.
REQ-028 The top level SHALL contain no decoder logic; digit SHALL drive the existing 7-segment decoder unchanged.

Verification (CLK_HZ=4 in simulation)
REQ-029 The bench SHALL cover: reset, speed=00, up=1, enable=1 for 17 clocks -> digit 1,2,…,F,0,1 and tick high every cycle.
REQ-030 The bench SHALL cover: speed=01 from reset, enable=1 -> reload on edge 1, then digit increments every 4 clocks with tick one cycle wide.
REQ-031 The bench SHALL cover: speed=11, up=0, digit=0 -> after 16 clocks digit=F, then E after 16 more.
REQ-032 The bench SHALL cover: load=1, load_value=A with enable=1 and div_cnt==0 -> digit=A, no step, tick=0, next step 4 clocks later at speed 01.
REQ-033 The bench SHALL cover: speed 01->10 mid-period -> tick suppressed that cycle, next step exactly 8 clocks after the change edge.
REQ-034 The bench SHALL cover: enable=0 for 10 clocks mid-period, then 1 -> digit and residual count preserved, step after the remaining clocks; resetn pulse mid-period -> digit=0 immediately, asynchronously.
